// File: rtl/ControlTypeDefs.sv
// Shared control-path types for the five-stage core: decode instruction classes,
// hazard sequencer states and the canonical NOP used by the flush muxes.
package ControlTypeDefs;

    typedef enum logic [3:0] {
        REG_COMMPUTATION,
        IMM_COMPUTATION,
        LOAD,
        STORE,
        BRANCH,
        JUMP,
        JAL,
        UPPER,
        SYSTEM
    } InstructionTypes;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } HazardState;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic uses_rs1(InstructionTypes t);
        return !(t inside {UPPER, JUMP, JAL});
    endfunction

    function automatic logic uses_rs2(InstructionTypes t);
        return t inside {REG_COMMPUTATION, STORE, BRANCH};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at LIMIT; clear has priority over increment.
module sat_counter #(
    parameter int unsigned            WIDTH = 8,
    parameter logic [WIDTH-1:0]       LIMIT = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: load-use interlock, redirect flushes and data-memory wait
// states, with a sticky wait timeout and a saturating stall-cycle counter.
module hazard_controller
    import ControlTypeDefs::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  InstructionTypes  iDecodeType,
    input  logic [4:0]       iDecodeRs1,
    input  logic [4:0]       iDecodeRs2,
    input  logic [4:0]       iExecRd,
    input  logic             iExecIsLoad,
    input  logic             iExecRedirect,
    input  logic             iMemReq,
    input  logic             iMemReady,
    output logic             oStallFetch,
    output logic             oStallDecode,
    output logic             oStallExecute,
    output logic             oStallMemory,
    output logic             oFlushDecode,
    output logic             oFlushExecute,
    output logic             oBubbleExecute,
    output logic             oMemTimeout,
    output logic [CNT_W-1:0] oStallCount,
    output logic [1:0]       oState
);

    localparam int unsigned        WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    HazardState        state, state_next;
    logic              flush_pending, set_pending, clear_pending;
    logic              timeout;
    logic              miss, load_use;
    logic [WAIT_W-1:0] wait_cnt;

    assign miss     = iMemReq && !iMemReady;
    assign load_use = iExecIsLoad && (iExecRd != 5'd0) &&
                      ((uses_rs1(iDecodeType) && iDecodeRs1 == iExecRd) ||
                       (uses_rs2(iDecodeType) && iDecodeRs2 == iExecRd));

    // A miss outranks a redirect: execute is frozen, so the redirect is re-presented.
    always_comb begin
        {oStallFetch, oStallDecode, oStallExecute, oStallMemory} = '0;
        {oFlushDecode, oFlushExecute, oBubbleExecute}             = '0;
        set_pending   = 1'b0;
        clear_pending = 1'b0;
        state_next    = state;
        if (iRstN) begin
            case (state)
                RUN: begin
                    if (miss) begin
                        {oStallFetch, oStallDecode, oStallExecute, oStallMemory} = '1;
                        state_next = MEM_WAIT;
                    end else if (iExecRedirect) begin
                        {oFlushDecode, oFlushExecute} = '1;
                        state_next = FLUSH;
                    end else if (load_use) begin
                        {oStallFetch, oStallDecode, oBubbleExecute} = '1;
                    end
                end
                FLUSH: begin
                    oFlushDecode = 1'b1;
                    state_next   = RUN;
                    if (miss) begin
                        {oStallFetch, oStallDecode, oStallExecute, oStallMemory} = '1;
                        set_pending = 1'b1;
                        state_next  = MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    {oStallFetch, oStallDecode, oStallExecute, oStallMemory} = {4{!iMemReady}};
                    if (iMemReady) begin
                        oFlushDecode  = flush_pending;
                        clear_pending = 1'b1;
                        state_next    = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state         <= RUN;
            flush_pending <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state <= state_next;
            if (set_pending) begin
                flush_pending <= 1'b1;
            end else if (clear_pending) begin
                flush_pending <= 1'b0;
            end
            // Raised on the edge where the wait count reaches MAX_WAIT.
            if (state == MEM_WAIT && !iMemReady && wait_cnt >= WAIT_LAST) begin
                timeout <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (WAIT_W),
        .LIMIT (WAIT_MAX)
    ) u_wait_cnt (
        .clk   (iClk),
        .rst_n (iRstN),
        .inc   (state == MEM_WAIT),
        .clear (state != MEM_WAIT || iMemReady),
        .count (wait_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT ({CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk   (iClk),
        .rst_n (iRstN),
        .inc   (oStallFetch),
        .clear (1'b0),
        .count (oStallCount)
    );

    assign oMemTimeout = timeout;
    assign oState      = state;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller against a cycle-level behavioural model.
module tb_hazard_controller;
    import ControlTypeDefs::*;

    localparam int MAX_WAIT  = 15;
    localparam int CNT_W     = 5;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    InstructionTypes d_type;
    logic [4:0]      d_rs1, d_rs2, e_rd;
    logic            e_load, e_redir, m_req, m_rdy;
    logic            sf, sd, se, sm, fd, fe, be, tmo;
    logic [CNT_W-1:0] scount;
    logic [1:0]      st;

    hazard_controller #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .iClk           (clk),
        .iRstN          (rstn),
        .iDecodeType    (d_type),
        .iDecodeRs1     (d_rs1),
        .iDecodeRs2     (d_rs2),
        .iExecRd        (e_rd),
        .iExecIsLoad    (e_load),
        .iExecRedirect  (e_redir),
        .iMemReq        (m_req),
        .iMemReady      (m_rdy),
        .oStallFetch    (sf),
        .oStallDecode   (sd),
        .oStallExecute  (se),
        .oStallMemory   (sm),
        .oFlushDecode   (fd),
        .oFlushExecute  (fe),
        .oBubbleExecute (be),
        .oMemTimeout    (tmo),
        .oStallCount    (scount),
        .oState         (st)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0=RUN 1=FLUSH 2=MEM_WAIT; e_ctrl = {sf,sd,se,sm,fd,fe,be}
    int         m_mode;
    bit         m_pending;
    int         m_waits;
    bit         m_timeout;
    int         m_stalls;
    logic [6:0] e_ctrl;
    int         e_next;

    task automatic model_reset();
        m_mode = 0; m_pending = 0; m_waits = 0; m_timeout = 0; m_stalls = 0;
    endtask

    task automatic model_eval();
        bit miss, r1, r2, hazard;
        miss   = m_req && !m_rdy;
        r1     = !(d_type == UPPER || d_type == JUMP || d_type == JAL);
        r2     = (d_type == REG_COMMPUTATION || d_type == STORE || d_type == BRANCH);
        hazard = e_load && e_rd != 0 && ((r1 && d_rs1 == e_rd) || (r2 && d_rs2 == e_rd));
        e_ctrl = '0;
        e_next = m_mode;
        if (rstn) begin
            if (m_mode == 0) begin
                if (miss) begin e_ctrl = 7'b1111_000; e_next = 2; end
                else if (e_redir) begin e_ctrl = 7'b0000_110; e_next = 1; end
                else if (hazard) e_ctrl = 7'b1100_001;
            end else if (m_mode == 1) begin
                e_ctrl = miss ? 7'b1111_100 : 7'b0000_100;
                e_next = miss ? 2 : 0;
            end else begin
                if (m_rdy) begin e_ctrl = {4'b0000, m_pending, 2'b00}; e_next = 0; end
                else e_ctrl = 7'b1111_000;
            end
        end
    endtask

    task automatic model_clock();
        if (!rstn) begin
            model_reset();
        end else begin
            if (e_ctrl[6] && m_stalls < STALL_MAX) m_stalls++;
            if (m_mode == 1 && m_req && !m_rdy) m_pending = 1;
            if (m_mode == 2 && m_rdy) m_pending = 0;
            if (m_mode == 2 && !m_rdy) begin
                if (m_waits < MAX_WAIT) m_waits++;
                if (m_waits == MAX_WAIT) m_timeout = 1;
            end else begin
                m_waits = 0;
            end
            m_mode = e_next;
        end
    endtask

    task automatic drive(input InstructionTypes t, input int r1, input int r2, input int rd,
                         input bit ld, input bit rdr, input bit rq, input bit rdy);
        d_type = t; d_rs1 = 5'(r1); d_rs2 = 5'(r2); e_rd = 5'(rd);
        e_load = ld; e_redir = rdr; m_req = rq; m_rdy = rdy;
        model_eval();
    endtask

    task automatic drive_rand(input int redir_pct, input int req_pct);
        drive(InstructionTypes'(4'($urandom_range(8, 0))), int'($urandom_range(3, 0)),
              int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), $urandom_range(1, 0) == 1,
              int'($urandom_range(99, 0)) < redir_pct, int'($urandom_range(99, 0)) < req_pct,
              $urandom_range(99, 0) < 60);
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        drive(IMM_COMPUTATION, 0, 0, 0, 0, 0, 0, 0);
        advance();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive_rand(50, 80);
            @(negedge clk);
            checks++;
            if ({sf, sd, se, sm, fd, fe, be} !== 7'b0) begin
                failures++; $display("FAIL reset_ctrl cyc=%0d got=%b want=%b", i, {sf, sd, se, sm, fd, fe, be}, 7'b0);
            end
            checks++;
            if ({st, tmo, scount} !== '0) begin
                failures++; $display("FAIL reset_status cyc=%0d got=%h want=0", i, {st, tmo, scount});
            end
            advance();
        end
        rstn = 1'b1;
    endtask

    task automatic test_load_use();
        InstructionTypes ty [7] = '{REG_COMMPUTATION, REG_COMMPUTATION, REG_COMMPUTATION, UPPER,
                                    STORE, IMM_COMPUTATION, JAL};
        int r1 [7] = '{5, 5, 0, 7, 1, 2, 3};
        int r2 [7] = '{0, 0, 0, 0, 9, 9, 0};
        int rd [7] = '{5, 5, 0, 7, 9, 9, 3};
        bit ld [7] = '{1, 0, 1, 1, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 47; i++) begin
            if (i < 7) drive(ty[i], r1[i], r2[i], rd[i], ld[i], 0, 0, 0);
            else drive_rand(0, 0);
            @(negedge clk);
            checks++;
            if ({sf, sd, se, sm, fd, fe, be} !== e_ctrl) begin
                failures++; $display("FAIL load_use_ctrl cyc=%0d got=%b want=%b", i, {sf, sd, se, sm, fd, fe, be}, e_ctrl);
            end
            checks++;
            if ({st, tmo, scount} !== {2'(m_mode), m_timeout, CNT_W'(m_stalls)}) begin
                failures++; $display("FAIL load_use_status cyc=%0d got=%h want=%h", i, {st, tmo, scount},
                                     {2'(m_mode), m_timeout, CNT_W'(m_stalls)});
            end
            advance();
            if (i == 6) begin
                checks++;
                if (scount !== 5'd2) begin
                    failures++; $display("FAIL load_use_count got=%0d want=2", scount);
                end
            end
        end
    endtask

    task automatic test_redirect();
        int exp_st [3] = '{0, 1, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(REG_COMMPUTATION, 4, 0, 4, 1, 1, 0, 0);
            else if (i == 1) drive(REG_COMMPUTATION, 4, 0, 4, 1, 0, 0, 0);
            else drive(IMM_COMPUTATION, 1, 1, 2, 0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if ({sf, sd, se, sm, fd, fe, be} !== e_ctrl) begin
                failures++; $display("FAIL redirect_ctrl cyc=%0d got=%b want=%b", i, {sf, sd, se, sm, fd, fe, be}, e_ctrl);
            end
            checks++;
            if (st !== 2'(exp_st[i])) begin
                failures++; $display("FAIL redirect_state cyc=%0d got=%0d want=%0d", i, st, exp_st[i]);
            end
            advance();
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(LOAD, 1, 2, 3, 0, 0, 1, 0);
            else if (i == 3) drive(LOAD, 1, 2, 3, 0, 0, 1, 1);
            else drive(LOAD, 1, 2, 3, 0, 0, 0, 1);
            @(negedge clk);
            checks++;
            if ({sf, sd, se, sm, fd, fe, be} !== e_ctrl) begin
                failures++; $display("FAIL mem_wait_ctrl cyc=%0d got=%b want=%b", i, {sf, sd, se, sm, fd, fe, be}, e_ctrl);
            end
            checks++;
            if ({st, tmo, scount} !== {2'(m_mode), m_timeout, CNT_W'(m_stalls)}) begin
                failures++; $display("FAIL mem_wait_status cyc=%0d got=%h want=%h", i, {st, tmo, scount},
                                     {2'(m_mode), m_timeout, CNT_W'(m_stalls)});
            end
            advance();
        end
        checks++;
        if ({st, tmo, scount} !== {2'd0, 1'b0, 5'd3}) begin
            failures++; $display("FAIL mem_wait_final got=%h want=%h", {st, tmo, scount}, {2'd0, 1'b0, 5'd3});
        end
    endtask

    task automatic test_timeout();
        int first_tmo = -1;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(STORE, 1, 2, 3, 0, 0, 1, i >= 20);
            @(negedge clk);
            if (tmo === 1'b1 && first_tmo < 0) first_tmo = i;
            checks++;
            if ({sf, sd, se, sm, fd, fe, be} !== e_ctrl) begin
                failures++; $display("FAIL timeout_ctrl cyc=%0d got=%b want=%b", i, {sf, sd, se, sm, fd, fe, be}, e_ctrl);
            end
            checks++;
            if ({st, tmo, scount} !== {2'(m_mode), m_timeout, CNT_W'(m_stalls)}) begin
                failures++; $display("FAIL timeout_status cyc=%0d got=%h want=%h", i, {st, tmo, scount},
                                     {2'(m_mode), m_timeout, CNT_W'(m_stalls)});
            end
            advance();
        end
        checks++;
        if (first_tmo != 16) begin
            failures++; $display("FAIL timeout_rise got_cycle=%0d want_cycle=16", first_tmo);
        end
        rstn = 1'b0;
        #2;
        checks++;
        if (tmo !== 1'b0) begin
            failures++; $display("FAIL timeout_clear got=%b want=0", tmo);
        end
        model_reset();
        advance();
        rstn = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 41; i++) begin
            drive(BRANCH, 1, 2, 3, 0, 0, 1, i == 40);
            @(negedge clk);
            checks++;
            if ({st, tmo, scount} !== {2'(m_mode), m_timeout, CNT_W'(m_stalls)}) begin
                failures++; $display("FAIL saturate_status cyc=%0d got=%h want=%h", i, {st, tmo, scount},
                                     {2'(m_mode), m_timeout, CNT_W'(m_stalls)});
            end
            advance();
        end
        checks++;
        if (scount !== 5'h1F) begin
            failures++; $display("FAIL saturate_count got=%0d want=31", scount);
        end
    endtask

    task automatic test_flush_miss();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 5; i++) begin
                case (i)
                    0: drive(REG_COMMPUTATION, 1, 2, 3, 0, 1, 0, 0);
                    1, 2: drive(REG_COMMPUTATION, 1, 2, 3, 0, 0, 1, 0);
                    3: begin
                        if (pass == 1) begin rstn = 1'b0; model_reset(); end
                        drive(REG_COMMPUTATION, 1, 2, 3, 0, 0, 1, pass == 0);
                    end
                    default: begin
                        rstn = 1'b1;
                        drive(REG_COMMPUTATION, 1, 2, 3, 0, 0, 1, 1);
                    end
                endcase
                @(negedge clk);
                checks++;
                if ({sf, sd, se, sm, fd, fe, be} !== e_ctrl) begin
                    failures++; $display("FAIL flush_miss_ctrl pass=%0d cyc=%0d got=%b want=%b", pass, i,
                                         {sf, sd, se, sm, fd, fe, be}, e_ctrl);
                end
                checks++;
                if ({st, tmo, scount} !== {2'(m_mode), m_timeout, CNT_W'(m_stalls)}) begin
                    failures++; $display("FAIL flush_miss_status pass=%0d cyc=%0d got=%h want=%h", pass, i,
                                         {st, tmo, scount}, {2'(m_mode), m_timeout, CNT_W'(m_stalls)});
                end
                if (i == 3 && pass == 0) begin
                    checks++;
                    if (fd !== 1'b1) begin
                        failures++; $display("FAIL flush_miss_reflush got=%b want=1", fd);
                    end
                end
                if (i == 4 && pass == 1) begin
                    checks++;
                    if ({fd, st} !== 3'b000) begin
                        failures++; $display("FAIL flush_miss_reset_drop got=%b want=000", {fd, st});
                    end
                end
                advance();
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive_rand(20, 40);
            @(negedge clk);
            checks++;
            if ({sf, sd, se, sm, fd, fe, be} !== e_ctrl) begin
                failures++; $display("FAIL random_ctrl cyc=%0d got=%b want=%b", i, {sf, sd, se, sm, fd, fe, be}, e_ctrl);
            end
            checks++;
            if ({st, tmo, scount} !== {2'(m_mode), m_timeout, CNT_W'(m_stalls)}) begin
                failures++; $display("FAIL random_status cyc=%0d got=%h want=%h", i, {st, tmo, scount},
                                     {2'(m_mode), m_timeout, CNT_W'(m_stalls)});
            end
            advance();
        end
    endtask

    initial begin
        rstn = 1'b0;
        model_reset();
        drive(IMM_COMPUTATION, 0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_flush_miss();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
